// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU instruction/data memory-port arbiter.
// One-hot state encodings, owner identifiers and default bus widths.
package cpu_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 32;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_REQ  = 3'b010,
    ARB_RESP = 3'b100
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/cpu_mem_arbiter_perf_counter.sv
// Free-running wrap-around event counter used for the arbiter's perf outputs.
module arb_perf_counter
  import cpu_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU fetch and
// load/store channels; one outstanding transaction, responses routed to owner.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_req_valid,
  output logic                inst_req_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  input  logic                inst_ack,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic                data_we,
  input  logic                data_re,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_req_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rvalid,
  input  logic                data_rack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [31:0]         cnt_inst_grant,
  output logic [31:0]         cnt_data_grant,
  output logic [31:0]         cnt_conflict,
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and *_req_ack mirrors mem_req_ready
  // combinationally for the owner while the request is presented.

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic inst_pend, data_pend;
  logic pick;
  logic owner_rready;
  logic inst_grant_en, data_grant_en, conflict_en;

  assign inst_pend = inst_req_valid;
  assign data_pend = data_we | data_re;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    pick          = OWN_INST;
    owner_rready  = 1'b0;
    mem_req_valid = 1'b0;
    mem_rready    = 1'b0;
    inst_req_ack  = 1'b0;
    data_req_ack  = 1'b0;
    inst_valid    = 1'b0;
    data_rvalid   = 1'b0;
    inst_rdata    = '0;
    data_rdata    = '0;
    inst_grant_en = 1'b0;
    data_grant_en = 1'b0;
    conflict_en   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        conflict_en = inst_pend & data_pend;
        if (inst_pend | data_pend) begin
          // On a tie the channel that did not win last time goes first.
          if (inst_pend & data_pend) begin
            pick = ~last_q;
          end else begin
            pick = data_pend ? OWN_DATA : OWN_INST;
          end
          owner_d = pick;
          last_d  = pick;
          if (pick == OWN_DATA) begin
            addr_d        = data_addr;
            wdata_d       = data_wdata;
            wstrb_d       = data_wstrb;
            we_d          = data_we;
            data_grant_en = 1'b1;
          end else begin
            addr_d        = inst_addr;
            wdata_d       = '0;
            wstrb_d       = '0;
            we_d          = 1'b0;
            inst_grant_en = 1'b1;
          end
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        conflict_en   = (owner_q == OWN_INST) ? data_pend : inst_pend;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          inst_req_ack = (owner_q == OWN_INST);
          data_req_ack = (owner_q == OWN_DATA);
          state_d      = we_q ? ARB_IDLE : ARB_RESP;
        end
      end

      ARB_RESP: begin
        conflict_en  = (owner_q == OWN_INST) ? data_pend : inst_pend;
        owner_rready = (owner_q == OWN_INST) ? inst_ack : data_rack;
        mem_rready   = owner_rready;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        inst_valid   = (owner_q == OWN_INST) & mem_rvalid;
        data_rvalid  = (owner_q == OWN_DATA) & mem_rvalid;
        if (mem_rvalid & owner_rready) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= OWN_DATA;
      owner_q <= OWN_INST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign dbg_state = state_q;

  arb_perf_counter u_cnt_inst (
    .clk   (clk),
    .rst_n (rst),
    .en    (inst_grant_en),
    .cnt   (cnt_inst_grant)
  );

  arb_perf_counter u_cnt_data (
    .clk   (clk),
    .rst_n (rst),
    .en    (data_grant_en),
    .cnt   (cnt_data_grant)
  );

  arb_perf_counter u_cnt_conflict (
    .clk   (clk),
    .rst_n (rst),
    .en    (conflict_en),
    .cnt   (cnt_conflict)
  );

endmodule
